// File: rtl/arb_rr_4_1.sv
`default_nettype none
// ============================================================================
// Module      : arb_rr_4_1
// Description : Four-requester round-robin arbiter with packet locking. It
//               drives the 2-bit select of the downstream 4:1 data mux and
//               owns the valid/ready handshake between four sources and one
//               consumer. A grant is held until the granted source completes
//               a packet (transfer with last) or an idle timeout expires.
//
// Parameters  : TIMEOUT   - cycles a locked grant may sit with its requester
//                           deasserted before forced release; 0 disables.
//
// Ports       : clk       in   1  rising-edge clock
//               rst       in   1  asynchronous active-high reset
//               req       in   4  per-source valid
//               req_last  in   4  per-source end-of-packet flag
//               out_ready in   1  downstream accepts the presented beat
//               sel       out  2  mux select, index of granted source
//               gnt       out  4  one-hot grant, zero when idle
//               out_valid out  1  presented beat is valid
//               out_last  out  1  presented beat ends the packet
//               in_ready  out  4  per-source accept (gnt & out_ready)
//
// Revision    : 1.0 - initial release
// ============================================================================
module arb_rr_4_1 #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] req_last,
    input  logic       out_ready,
    output logic [1:0] sel,
    output logic [3:0] gnt,
    output logic       out_valid,
    output logic       out_last,
    output logic [3:0] in_ready
);

    // Counter only has to reach TIMEOUT-1, so clog2(TIMEOUT) bits suffice.
    localparam int            CW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] c_cnt_max  = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam bit            c_tmo_en   = (TIMEOUT > 0);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t        r_state;
    logic [1:0]    r_sel;
    logic [3:0]    r_gnt;
    logic [1:0]    r_ptr;
    logic [CW-1:0] r_cnt;

    logic          w_lock;
    logic          w_req_sel;
    logic          w_tmo;
    logic          w_release;
    logic          w_any;
    logic [1:0]    w_start;
    logic [1:0]    w_win;

    // Round-robin search: first set bit of r at or after start, wrapping 3->0.
    // Iterating from the farthest offset down lets the nearest one win.
    function automatic logic [1:0] f_pick(input logic [3:0] r, input logic [1:0] start);
        logic [1:0] idx;
        f_pick = start;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (r[idx]) begin
                f_pick = idx;
            end
        end
    endfunction

    always_comb begin
        w_lock    = (r_state == LOCK);
        w_req_sel = req[r_sel];
        out_valid = w_lock & w_req_sel;
        out_last  = out_valid & req_last[r_sel];
        in_ready  = r_gnt & {4{out_ready}};

        w_tmo     = c_tmo_en && w_lock && !w_req_sel && (r_cnt == c_cnt_max);
        w_release = (out_valid & out_ready & out_last) | w_tmo;

        // While locked the search for the next owner starts just past the
        // current owner, so the releasing source is considered last.
        w_start   = w_lock ? (r_sel + 2'd1) : r_ptr;
        w_any     = |req;
        w_win     = f_pick(req, w_start);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_sel   <= 2'b00;
            r_gnt   <= 4'b0000;
            r_ptr   <= 2'b00;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state <= LOCK;
                        r_sel   <= w_win;
                        r_gnt   <= 4'b0001 << w_win;
                        r_cnt   <= '0;
                    end
                end
                LOCK: begin
                    if (w_release) begin
                        r_ptr <= r_sel + 2'd1;
                        r_cnt <= '0;
                        if (w_any) begin
                            // Back-to-back hand-over, no idle bubble.
                            r_sel <= w_win;
                            r_gnt <= 4'b0001 << w_win;
                        end else begin
                            r_state <= IDLE;
                            r_gnt   <= 4'b0000;
                        end
                    end else if (c_tmo_en) begin
                        r_cnt <= w_req_sel ? '0 : (r_cnt + CW'(1));
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_gnt   <= 4'b0000;
                end
            endcase
        end
    end

    assign sel = r_sel;
    assign gnt = r_gnt;

endmodule
`default_nettype wire
